dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single DMEM port (ena/we/11-bit addr/data_w/data_sign/32-bit wdata/rdata) between the CPU core and a secondary loader/debug master. The block sits between cpu, dmem and the loader.
- CPU has default ownership.
- The loader is granted the port when the CPU is idle, or after a bounded starvation time.
- While the loader owns the port, the CPU is frozen via cpu_stall.
- Loader reads return registered data one cycle after grant.

Parameters:
STARVE_MAX, 4, consecutive CPU-busy cycles a pending loader request may wait before forced grant (>=1)
MAX_BURST, 8, maximum consecutive loader beats per ownership while ldr_lock held (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
cpu_ena  input  1  CPU DMEM access enable
cpu_we  input  1  CPU write enable
cpu_addr  input  11  CPU DMEM address
cpu_data_w  input  3  CPU access width code (passed through)
cpu_data_sign  input  1  CPU sign-extend select (passed through)
cpu_wdata  input  32  CPU write data
cpu_rdata  output  32  CPU read data
cpu_stall  output  1  freeze CPU (PC/regfile write inhibit)
ldr_req  input  1  loader access request, held until granted
ldr_lock  input  1  loader requests burst continuation
ldr_we  input  1  loader write enable
ldr_addr  input  11  loader address
ldr_data_w  input  3  loader width code
ldr_data_sign  input  1  loader sign select
ldr_wdata  input  32  loader write data
ldr_gnt  output  1  loader beat accepted this cycle
ldr_rdata  output  32  registered loader read data
ldr_rvalid  output  1  ldr_rdata valid pulse
dm_ena  output  1  to DMEM ena
dm_we  output  1  to DMEM we
dm_addr  output  11  to DMEM DM_addr
dm_data_w  output  3  to DMEM data_w
dm_data_sign  output  1  to DMEM data_sign
dm_wdata  output  32  to DMEM DM_wdata
dm_rdata  input  32  from DMEM DM_rdata (combinational read)

Behaviour:
- FSM states: CPU_OWN (reset state), LDR_OWN. State register, starve_cnt, beat_cnt and ldr_rdata/ldr_rvalid regs are cleared asynchronously on rst=0.
- Reset values: cpu_stall=0, ldr_gnt=0, ldr_rvalid=0, ldr_rdata=0. dm_* follow the cpu_* inputs.

CPU_OWN:
- dm_* = cpu_* (combinational mux).
- cpu_rdata = dm_rdata. cpu_stall = 0. ldr_gnt = 0.
- starve_cnt: increments (saturating at STARVE_MAX) when ldr_req && cpu_ena; cleared when !ldr_req.
- Next state is LDR_OWN when ldr_req && (!cpu_ena || starve_cnt == STARVE_MAX). beat_cnt is cleared on that transition.

LDR_OWN:
- dm_* = ldr_*, with dm_ena = ldr_req and dm_we = ldr_req && ldr_we.
- cpu_stall = 1 for the whole cycle. cpu_rdata = 0.
- ldr_gnt = ldr_req.
- starve_cnt is cleared.
- Stay in LDR_OWN while ldr_req && ldr_lock && beat_cnt < MAX_BURST-1; beat_cnt increments on each granted beat.
- Otherwise return to CPU_OWN.
- After a MAX_BURST-limited exit, the CPU owns at least one cycle: a forced-exit flag blocks re-grant for that single cycle, even if cpu_ena=0.

Read return:
- A granted beat with ldr_we=0 captures dm_rdata into ldr_rdata at the clock edge.
- ldr_rvalid=1 for exactly the following cycle. Writes produce no rvalid.
- ldr_rdata holds its value until the next captured read.

Other rules:
- Grant latency: minimum 1 cycle from ldr_req rising (registered decision).
- ldr_req dropping while in LDR_OWN returns to CPU_OWN next cycle with no grant.
- Simultaneous cpu_ena and grant transition: the CPU access in that CPU_OWN cycle completes; the stall begins next cycle.
- Reset asserted mid-burst: immediate CPU_OWN. An in-flight rvalid is suppressed.
- Widths pass through unchanged; no address translation.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs stat_stall_cyc[31:0] (counts LDR_OWN cycles) and stat_ldr_beats[31:0] (counts ldr_gnt cycles). Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- CPU idle (cpu_ena=0); ldr_req read addr 0x010 with DMEM[0x010]=0xDEADBEEF -> cycle+1: ldr_gnt=1, cpu_stall=1, dm_addr=0x010; cycle+2: ldr_rvalid=1, ldr_rdata=0xDEADBEEF.
- cpu_ena=1 continuously, STARVE_MAX=4, ldr_req held, ldr_lock=0 -> first ldr_gnt 5 cycles after req, a single stall cycle, then CPU_OWN; ldr_req held again -> next grant after the same 5-cycle wait.
- Burst: MAX_BURST=8, ldr_lock=1, ldr_req held for 10 beats, cpu_ena=0 -> 8 consecutive gnt cycles, exactly 1 CPU_OWN cycle (stall=0), then the remaining 2 beats granted.
- Loader write: ldr_we=1, addr 0x7FF, ldr_data_w=word, wdata 0x12345678 -> in the gnt cycle dm_ena=1, dm_we=1, dm_addr=0x7FF, dm_wdata=0x12345678; no rvalid; subsequent CPU read of 0x7FF returns 0x12345678.
- rst driven to 0 on the 3rd beat of a locked burst -> asynchronously cpu_stall=0, ldr_gnt=0, ldr_rvalid=0, dm_* = cpu_*; after release the FSM is in CPU_OWN with starve_cnt=0.
- ARB_STATS_EN defined; run scenario 3 -> stat_stall_cyc=10, stat_ldr_beats=10.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DMEM port between the CPU core (default
// owner) and a loader/debug master. The loader wins the port when the CPU is
// idle or after STARVE_MAX consecutive CPU-busy cycles, may hold it for up to
// MAX_BURST locked beats, and freezes the CPU via cpu_stall while it owns it.
// Loader reads come back registered, one cycle after the granted beat.
//
// Optional feature macro: ARB_STATS_EN adds the stat_stall_cyc and
// stat_ldr_beats utilisation counters.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        rst,
  // CPU side
  input  logic        cpu_ena,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [2:0]  cpu_data_w,
  input  logic        cpu_data_sign,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  // Loader side
  input  logic        ldr_req,
  input  logic        ldr_lock,
  input  logic        ldr_we,
  input  logic [10:0] ldr_addr,
  input  logic [2:0]  ldr_data_w,
  input  logic        ldr_data_sign,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_gnt,
  output logic [31:0] ldr_rdata,
  output logic        ldr_rvalid,
  // DMEM side
  output logic        dm_ena,
  output logic        dm_we,
  output logic [10:0] dm_addr,
  output logic [2:0]  dm_data_w,
  output logic        dm_data_sign,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] stat_stall_cyc,
  output logic [31:0] stat_ldr_beats
`endif
);

  // Counter widths sized so the terminal values themselves are representable.
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST - 1);

  typedef enum logic {
    CPU_OWN = 1'b0,
    LDR_OWN = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           rvalid_q, rvalid_d;

  // Ownership decision, port mux and counter next-state. The decision is made
  // from registered state, so every exit from LDR_OWN (including a burst-limit
  // exit) leaves the CPU at least one full cycle of ownership before the
  // loader can be granted again.
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    beat_d       = beat_q;
    dm_ena       = cpu_ena;
    dm_we        = cpu_we;
    dm_addr      = cpu_addr;
    dm_data_w    = cpu_data_w;
    dm_data_sign = cpu_data_sign;
    dm_wdata     = cpu_wdata;
    cpu_rdata    = dm_rdata;
    cpu_stall    = 1'b0;
    ldr_gnt      = 1'b0;

    case (state_q)
      CPU_OWN: begin
        // Starvation is only measured while a request is actually pending.
        if (!ldr_req) begin
          starve_d = '0;
        end else if (cpu_ena && (starve_q != STARVE_TOP)) begin
          starve_d = starve_q + 1'b1;
        end
        // The CPU access of this cycle still completes; the stall starts
        // on the next cycle.
        if (ldr_req && (!cpu_ena || (starve_q == STARVE_TOP))) begin
          state_d = LDR_OWN;
          beat_d  = '0;
        end
      end

      LDR_OWN: begin
        dm_ena       = ldr_req;
        dm_we        = ldr_req && ldr_we;
        dm_addr      = ldr_addr;
        dm_data_w    = ldr_data_w;
        dm_data_sign = ldr_data_sign;
        dm_wdata     = ldr_wdata;
        cpu_rdata    = '0;
        cpu_stall    = 1'b1;
        ldr_gnt      = ldr_req;
        starve_d     = '0;
        if (ldr_req) begin
          beat_d = beat_q + 1'b1;
        end
        // Continue only on a locked request that still has burst budget.
        if (!(ldr_req && ldr_lock && (beat_q < BEAT_LAST))) begin
          state_d = CPU_OWN;
        end
      end

      default: begin
        state_d = CPU_OWN;
      end
    endcase
  end

  // Read return: a granted loader read captures DMEM data; the value is held
  // until the next captured read, and rvalid pulses for one cycle.
  always_comb begin
    rvalid_d = ldr_gnt && !ldr_we;
    rdata_d  = rvalid_d ? dm_rdata : rdata_q;
  end

  // State and counter registers; reset forces immediate CPU ownership and
  // drops any in-flight read return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= CPU_OWN;
      starve_q <= '0;
      beat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign ldr_rdata  = rdata_q;
  assign ldr_rvalid = rvalid_q;

`ifdef ARB_STATS_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [31:0] ldr_beats_q, ldr_beats_d;

  // Utilisation counters: loader-owned cycles and granted beats, wrapping.
  always_comb begin
    stall_cyc_d = stall_cyc_q + ((state_q == LDR_OWN) ? 32'd1 : 32'd0);
    ldr_beats_d = ldr_beats_q + (ldr_gnt ? 32'd1 : 32'd0);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_q <= '0;
      ldr_beats_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      ldr_beats_q <= ldr_beats_d;
    end
  end

  assign stat_stall_cyc = stall_cyc_q;
  assign stat_ldr_beats = ldr_beats_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
